// File: rtl/pixel_fetch_dma.sv
// Avalon-MM pixel fetch DMA: CSR-programmed burst of pipelined reads into a show-ahead FIFO.
// Optional stall counter at CSR 3 is built when PIXEL_FETCH_STALLCNT_EN is defined.
module pixel_fetch_dma #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned SumW  = PtrW + 2;

  typedef enum logic [1:0] {StIdle, StFetch, StFlush} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [31:0]       r_src;
  logic [CNT_W-1:0]  r_count;
  logic              r_done;
  logic [ADDR_W-1:0] r_issue_ptr;
  logic [CNT_W-1:0]  r_job_count;
  logic [CNT_W-1:0]  r_issued;
  logic [FillW-1:0]  r_outstanding;
  logic [FillW-1:0]  r_fifo_count;
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [31:0]       r_mem [FIFO_DEPTH];

  logic              w_busy;
  logic              w_start;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_credit;
  logic              w_last_issue;
  logic              w_job_end;
  logic [CNT_W-1:0]  w_issued_next;
  logic [31:0]       w_stalls;

  assign w_busy        = (r_state != StIdle);
  assign w_start       = csr_write && (csr_address == 2'd2) && csr_writedata[0] && !w_busy;
  assign w_fifo_empty  = (r_fifo_count == '0);
  // Credit: entries held plus reads in flight never exceed the FIFO size.
  assign w_credit      = ({1'b0, r_fifo_count} + {1'b0, r_outstanding}) < SumW'(FIFO_DEPTH);
  assign w_accept      = m_read && !m_waitrequest;
  assign w_push        = m_readdatavalid && (r_outstanding != '0);
  assign w_pop         = out_valid && out_ready;
  assign w_issued_next = r_issued + CNT_W'(1);
  assign w_last_issue  = w_accept && (w_issued_next == r_job_count);
  assign w_job_end     = (r_state == StFlush) && (r_outstanding == '0) && w_fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_next = (r_count == '0) ? StFlush : StFetch;
      StFetch: if (w_last_issue) w_state_next = StFlush;
      StFlush: if (w_job_end) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    m_read    = (r_state == StFetch) && (r_issued < r_job_count) && w_credit;
    m_address = r_issue_ptr;
    out_valid = !w_fifo_empty;
    out_data  = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src   <= '0;
      r_count <= '0;
    end else if (csr_write) begin
      case (csr_address)
        2'd0:    r_src   <= csr_writedata & ~32'h3;
        2'd1:    r_count <= csr_writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Job parameters are latched at start so CSR writes mid-job do not disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_ptr <= '0;
      r_job_count <= '0;
      r_issued    <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_issue_ptr <= ADDR_W'(r_src);
        r_job_count <= r_count;
        r_issued    <= '0;
        r_done      <= 1'b0;
      end else if (w_accept) begin
        r_issue_ptr <= r_issue_ptr + ADDR_W'(4);
        r_issued    <= w_issued_next;
      end
      if (w_job_end) r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      case ({w_accept, w_push})
        2'b10:   r_outstanding <= r_outstanding + FillW'(1);
        2'b01:   r_outstanding <= r_outstanding - FillW'(1);
        default: ;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + FillW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - FillW'(1);
        default: ;
      endcase
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= m_readdata;
  end

`ifdef PIXEL_FETCH_STALLCNT_EN
  logic [31:0] r_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stalls <= '0;
    end else if (w_start) begin
      r_stalls <= '0;
    end else if (w_busy && out_valid && !out_ready && (r_stalls != '1)) begin
      r_stalls <= r_stalls + 32'd1;
    end
  end

  assign w_stalls = r_stalls;
`else
  assign w_stalls = '0;
`endif

  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      case (csr_address)
        2'd0:    csr_readdata = r_src;
        2'd1:    csr_readdata = 32'(r_count);
        2'd2:    csr_readdata = {30'b0, r_done, w_busy};
        default: csr_readdata = w_stalls;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_fifo_count == FillW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_pixel_fetch_dma.sv
// Testbench for pixel_fetch_dma: memory slave model plus per-scenario tasks checking
// address order, delivered pixels, credit bound, CSR behaviour and reset recovery.
module tb_pixel_fetch_dma;
  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic [31:0] m_address;
  logic        m_read, m_waitrequest, m_readdatavalid;
  logic [31:0] m_readdata, out_data;
  logic        out_valid, out_ready;

  pixel_fetch_dma dut (
    .clk            (clk),
    .reset          (reset),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] data; int due;} pend_t;
  typedef struct {logic [31:0] pa; logic [31:0] ca; logic cr;} hold_t;

  pend_t       pend_q[$];
  hold_t       hold_q[$];
  logic [31:0] acc_q[$], beat_q[$], exp_a[$], exp_d[$];
  int          cyc, last_due, wr_mode, rdy_mode, lat_max, stall_left, read_seen, max_inflight;
  bit          inject_stale, prev_wait;
  logic [31:0] prev_addr;
  int          n_total, n_bad;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1010) return 32'hA0 + ((a - 32'h1000) >> 2);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Memory slave and stream sink; inputs change on negedge, DUT samples on posedge.
  always @(negedge clk) begin : slave
    pend_t p;
    bit    w;
    int    due;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    if (inject_stale) begin
      m_readdatavalid = 1'b1;
      m_readdata      = 32'hDEAD_BEEF;
      inject_stale    = 1'b0;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      m_readdatavalid = 1'b1;
      m_readdata      = p.data;
    end
    if (prev_wait) hold_q.push_back('{pa: prev_addr, ca: m_address, cr: m_read});
    case (wr_mode)
      1:       w = m_read && ($urandom_range(0, 2) == 0);
      2: begin
        w = m_read && (acc_q.size() == 1) && (stall_left > 0);
        if (w) stall_left--;
      end
      default: w = 1'b0;
    endcase
    m_waitrequest = w;
    prev_wait     = m_read && w;
    prev_addr     = m_address;
    if (m_read) read_seen++;
    if (m_read && !w) begin
      acc_q.push_back(m_address);
      due = cyc + $urandom_range(1, lat_max);
      if (due < last_due) due = last_due;
      last_due = due;
      pend_q.push_back('{data: word_at(m_address), due: due});
      if (acc_q.size() - beat_q.size() > max_inflight) max_inflight = acc_q.size() - beat_q.size();
    end
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 1) == 1);
    endcase
    if (out_valid && out_ready) beat_q.push_back(out_data);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    #1;
    d = csr_readdata;
    tick();
    csr_read = 1'b0;
  endtask

  task automatic clear_logs();
    acc_q.delete(); beat_q.delete(); hold_q.delete(); exp_a.delete(); exp_d.delete();
    read_seen = 0; max_inflight = 0;
  endtask

  task automatic start_job(input logic [31:0] src, input int cnt);
    logic [31:0] a;
    clear_logs();
    for (int i = 0; i < cnt; i++) begin
      a = (src & 32'hFFFF_FFFC) + 32'(i * 4);
      exp_a.push_back(a);
      exp_d.push_back(word_at(a));
    end
    csr_wr(2'd0, src);
    csr_wr(2'd1, 32'(cnt));
    csr_wr(2'd2, 32'h1);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      csr_rd(2'd2, s);
      if (s == 32'h2) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_total++;
    if (m_read !== 1'b0 || m_address !== 32'h0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: read=%b addr=%h valid=%b data=%h want 0", m_read, m_address,
               out_valid, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      csr_rd(2'(i), d);
      n_total++;
      if (d !== 32'h0) begin n_bad++; $display("FAIL reset_csr%0d: got %h want 0", i, d); end
    end
  endtask

  task automatic test_csr();
    logic [31:0] d, r;
    csr_wr(2'd0, 32'h1234_5677);
    csr_rd(2'd0, d);
    n_total++;
    if (d !== 32'h1234_5674) begin n_bad++; $display("FAIL csr_src: got %h want 12345674", d); end
    r = $urandom();
    csr_wr(2'd0, r);
    csr_rd(2'd0, d);
    n_total++;
    if (d !== (r & 32'hFFFF_FFFC)) begin
      n_bad++; $display("FAIL csr_src_rand: got %h want %h", d, r & 32'hFFFF_FFFC);
    end
    csr_wr(2'd1, 32'hABCD_1234);
    csr_rd(2'd1, d);
    n_total++;
    if (d !== 32'h0000_1234) begin n_bad++; $display("FAIL csr_count: got %h want 1234", d); end
    csr_rd(2'd3, d);
    n_total++;
    if (d !== 32'h0) begin n_bad++; $display("FAIL csr_stalls_idle: got %h want 0", d); end
  endtask

  task automatic test_basic();
    bit ok;
    wr_mode = 0; rdy_mode = 1; lat_max = 2;
    start_job(32'h1000, 4);
    wait_idle(60, ok);
    n_total++;
    if (!ok) begin n_bad++; $display("FAIL basic_done: status never 2, want 2"); end
    n_total++;
    if (acc_q.size() != 4 || beat_q.size() != 4) begin
      n_bad++; $display("FAIL basic_len: reads=%0d beats=%0d want 4", acc_q.size(), beat_q.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_total++;
      if (acc_q[i] !== exp_a[i] || beat_q[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL basic_beat%0d: addr=%h data=%h want addr=%h data=%h", i, acc_q[i],
                 beat_q[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_count_zero();
    logic [31:0] s1, s2;
    clear_logs();
    csr_wr(2'd1, 32'h0);
    csr_wr(2'd2, 32'h1);
    csr_rd(2'd2, s1);
    csr_rd(2'd2, s2);
    repeat (4) tick();
    n_total++;
    if (s1 !== 32'h1 || s2 !== 32'h2) begin
      n_bad++; $display("FAIL zero_status: got %h then %h want 1 then 2", s1, s2);
    end
    n_total++;
    if (read_seen != 0) begin n_bad++; $display("FAIL zero_reads: got %0d want 0", read_seen); end
  endtask

  task automatic test_backpressure();
    bit ok;
    wr_mode = 0; rdy_mode = 0; lat_max = 1;
    start_job(32'h5000, 12);
    repeat (40) tick();
    n_total++;
    if (acc_q.size() != Depth || m_read !== 1'b0 || out_valid !== 1'b1 || beat_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_hold: reads=%0d m_read=%b valid=%b beats=%0d want 8 0 1 0", acc_q.size(),
               m_read, out_valid, beat_q.size());
    end
    rdy_mode = 1;
    wait_idle(100, ok);
    n_total++;
    if (!ok || acc_q.size() != 12 || beat_q.size() != 12 || max_inflight > Depth) begin
      n_bad++;
      $display("FAIL bp_drain: done=%b reads=%0d beats=%0d inflight=%0d want 1 12 12 <=8", ok,
               acc_q.size(), beat_q.size(), max_inflight);
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_total++;
      if (acc_q[i] !== exp_a[i] || beat_q[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL bp_beat%0d: addr=%h data=%h want addr=%h data=%h", i, acc_q[i], beat_q[i],
                 exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_waitrequest();
    bit ok;
    wr_mode = 2; stall_left = 3; rdy_mode = 1; lat_max = 1;
    start_job(32'h1000, 4);
    wait_idle(60, ok);
    wr_mode = 0;
    n_total++;
    if (!ok || hold_q.size() != 3) begin
      n_bad++; $display("FAIL wr_holds: done=%b holds=%0d want 1 3", ok, hold_q.size());
    end
    foreach (hold_q[i]) begin
      n_total++;
      if (hold_q[i].pa !== 32'h1004 || hold_q[i].ca !== 32'h1004 || hold_q[i].cr !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_hold%0d: addr %h->%h read=%b want 1004->1004 1", i, hold_q[i].pa,
                 hold_q[i].ca, hold_q[i].cr);
      end
    end
    n_total++;
    if (acc_q.size() != 4) begin n_bad++; $display("FAIL wr_count: got %0d want 4", acc_q.size()); end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_total++;
      if (acc_q[i] !== exp_a[i] || beat_q[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL wr_beat%0d: addr=%h data=%h want addr=%h data=%h", i, acc_q[i], beat_q[i],
                 exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [31:0] s, d0, d1;
    wr_mode = 0; rdy_mode = 0; lat_max = 2;
    start_job(32'h2000, 5);
    repeat (10) tick();
    csr_wr(2'd0, 32'h9000);
    csr_wr(2'd1, 32'd2);
    csr_wr(2'd2, 32'h1);
    csr_rd(2'd2, s);
    rdy_mode = 1;
    wait_idle(80, ok);
    csr_rd(2'd0, d0);
    csr_rd(2'd1, d1);
    n_total++;
    if (s !== 32'h1 || !ok || d0 !== 32'h9000 || d1 !== 32'd2) begin
      n_bad++;
      $display("FAIL busy_csr: status=%h done=%b src=%h cnt=%h want 1 1 9000 2", s, ok, d0, d1);
    end
    n_total++;
    if (acc_q.size() != 5 || beat_q.size() != 5) begin
      n_bad++; $display("FAIL busy_len: reads=%0d beats=%0d want 5", acc_q.size(), beat_q.size());
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_total++;
      if (acc_q[i] !== exp_a[i] || beat_q[i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL busy_beat%0d: addr=%h data=%h want addr=%h data=%h", i, acc_q[i],
                 beat_q[i], exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] s, d;
    int n;
    wr_mode = 0; rdy_mode = 1; lat_max = 2;
    start_job(32'h3000, 6);
    n = 0;
    while (beat_q.size() < 2 && n < 50) begin tick(); n++; end
    n_total++;
    if (beat_q.size() < 2) begin
      n_bad++; $display("FAIL rst_first_beats: got %0d want >=2", beat_q.size());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pend_q.delete();
    clear_logs();
    inject_stale = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || m_read !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_quiet%0d: valid=%b data=%h read=%b want 0 0 0", i, out_valid, out_data,
                 m_read);
      end
    end
    csr_rd(2'd2, s);
    csr_rd(2'd0, d);
    n_total++;
    if (s !== 32'h0 || d !== 32'h0 || beat_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_state: status=%h src=%h beats=%0d want 0 0 0", s, d, beat_q.size());
    end
  endtask

  task automatic test_stall_count();
    bit ok;
    int n;
    logic [31:0] d, want;
    wr_mode = 0; rdy_mode = 0; lat_max = 1;
    start_job(32'h4000, 4);
    n = 0;
    do begin tick(); n++; end while (out_valid !== 1'b1 && n < 30);
    repeat (5) tick();
    rdy_mode = 1;
    wait_idle(60, ok);
    csr_rd(2'd3, d);
`ifdef PIXEL_FETCH_STALLCNT_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    n_total++;
    if (!ok || d !== want) begin
      n_bad++; $display("FAIL stall_count: done=%b csr3=%0d want 1 %0d", ok, d, want);
    end
    for (int i = 0; i < exp_a.size(); i++) begin
      n_total++;
      if (beat_q[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL stall_beat%0d: got %h want %h", i, beat_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] src;
    int cnt;
    for (int j = 0; j < 6; j++) begin
      src = (j == 0) ? 32'hFFFF_FFF0 : $urandom();
      cnt = $urandom_range(1, 24);
      wr_mode = 1; rdy_mode = 2; lat_max = $urandom_range(1, 4);
      start_job(src, cnt);
      wait_idle(600, ok);
      n_total++;
      if (!ok || acc_q.size() != cnt || beat_q.size() != cnt || max_inflight > Depth) begin
        n_bad++;
        $display("FAIL rand%0d_job: done=%b reads=%0d beats=%0d inflight=%0d want 1 %0d %0d <=8",
                 j, ok, acc_q.size(), beat_q.size(), max_inflight, cnt, cnt);
      end
      for (int i = 0; i < exp_a.size(); i++) begin
        n_total++;
        if (acc_q[i] !== exp_a[i] || beat_q[i] !== exp_d[i]) begin
          n_bad++;
          $display("FAIL rand%0d_beat%0d: addr=%h data=%h want addr=%h data=%h", j, i, acc_q[i],
                   beat_q[i], exp_a[i], exp_d[i]);
        end
      end
      foreach (hold_q[i]) begin
        n_total++;
        if (hold_q[i].cr !== 1'b1 || hold_q[i].ca !== hold_q[i].pa) begin
          n_bad++;
          $display("FAIL rand%0d_hold%0d: addr %h->%h read=%b want stable with read=1", j, i,
                   hold_q[i].pa, hold_q[i].ca, hold_q[i].cr);
        end
      end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0; cyc = 0; last_due = 0;
    wr_mode = 0; rdy_mode = 1; lat_max = 1; stall_left = 0;
    inject_stale = 1'b0; prev_wait = 1'b0; prev_addr = '0;
    read_seen = 0; max_inflight = 0;
    reset = 1'b1;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    test_reset();
    test_csr();
    test_basic();
    test_count_zero();
    test_backpressure();
    test_waitrequest();
    test_start_while_busy();
    test_reset_mid_job();
    test_stall_count();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
